// File: rtl/instr_stream_loader_pkg.sv
// instr_stream_loader_pkg: shared 3BC field widths, opcode map and loader state names.
package instr_stream_loader_pkg;

    localparam int kOpW      = 4;
    localparam int kOperandW = 5;

    localparam logic [kOpW-1:0] kLDR     = 4'h5;
    localparam logic [kOpW-1:0] kADDI    = 4'hC;
    localparam logic [kOpW-1:0] kBNZL    = 4'hE;
    localparam logic [kOpW-1:0] kILLEGAL = 4'b1111;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE,
        ERROR
    } loaderState_t;

endpackage

// File: rtl/instr_pack.sv
// instr_pack: packs an (opcode, operand) pair into a 3BC word and flags the unmapped opcode.
//   op      in  opcode
//   operand in  register/immediate field
//   word    out {op, operand}
//   illegal out high for the unmapped opcode
module instr_pack
    import instr_stream_loader_pkg::*;
(
    input  logic [kOpW-1:0]           op,
    input  logic [kOperandW-1:0]      operand,
    output logic [kOpW+kOperandW-1:0] word,
    output logic                      illegal
);

    assign word    = {op, operand};
    assign illegal = op == kILLEGAL;

endmodule

// File: rtl/instr_stream_loader.sv
// instr_stream_loader: streams (opcode, operand) beats into instruction memory from address 0.
//   Clk, Reset       clock, synchronous active-high reset
//   Start            begins a load at address 0 (ignored while loading)
//   Op, Operand      beat payload; Last marks the final beat
//   InValid/InReady  beat handshake, InReady decoded from state only
//   WrEn/WrAddr/WrData  registered memory write port, one cycle per accepted legal beat
//   Busy, Done, Error   status from state; Count = words written this load
//   Checksum         running XOR of written words, only with LOADER_CHECKSUM_EN
module instr_stream_loader
    import instr_stream_loader_pkg::*;
#(
    parameter int IW = 9,
    parameter int AW = 10
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Start,
    input  logic [3:0]    Op,
    input  logic [4:0]    Operand,
    input  logic          Last,
    input  logic          InValid,
    output logic          InReady,
    output logic          WrEn,
    output logic [AW-1:0] WrAddr,
    output logic [IW-1:0] WrData,
    output logic          Busy,
    output logic          Done,
    output logic          Error,
    output logic [AW:0]   Count
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic [IW-1:0] Checksum
`endif
);

    loaderState_t state, nextState;
    logic [AW-1:0] addr;
    logic [kOpW+kOperandW-1:0] word;
    logic illegal, accept, write, atMax, restart;

    instr_pack uPack (
        .op      (Op),
        .operand (Operand),
        .word    (word),
        .illegal (illegal)
    );

    assign accept  = (state == LOAD) && InValid;
    assign write   = accept && !illegal;
    assign atMax   = &addr;
    assign restart = Start && (state != LOAD);

    // A legal non-final beat at the top address is still written, then the load aborts.
    always_comb begin
        nextState = state;
        InReady   = state == LOAD;
        Busy      = state == LOAD;
        Done      = state == DONE;
        Error     = state == ERROR;
        if (restart)
            nextState = LOAD;
        else if (accept)
            nextState = illegal ? ERROR : Last ? DONE : atMax ? ERROR : LOAD;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state  <= IDLE;
            addr   <= '0;
            WrEn   <= 1'b0;
            WrAddr <= '0;
            WrData <= '0;
            Count  <= '0;
        end else begin
            state <= nextState;
            WrEn  <= write;
            if (restart) begin
                addr  <= '0;
                Count <= '0;
            end else if (write) begin
                WrAddr <= addr;
                WrData <= IW'(word);
                addr   <= atMax ? addr : addr + 1'b1;
                Count  <= Count + 1'b1;
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge Clk) begin
        if (Reset || restart)
            Checksum <= '0;
        else if (WrEn)
            Checksum <= Checksum ^ WrData;
    end
`endif

endmodule

// File: tb/tb_instr_stream_loader.sv
// tb_instr_stream_loader: directed scoreboard bench for instr_stream_loader (AW=10 and AW=2 instances).
module tb_instr_stream_loader;
    import instr_stream_loader_pkg::*;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic Reset = 1'b1, Start = 1'b0, Start2 = 1'b0, Last = 1'b0, InValid = 1'b0, InValid2 = 1'b0;
    logic [3:0] Op = '0;
    logic [4:0] Operand = '0;

    logic InReady, WrEn, Busy, Done, Error;
    logic [9:0] WrAddr;
    logic [8:0] WrData, Checksum;
    logic [10:0] Count;
    logic InReady2, WrEn2, Busy2, Done2, Error2;
    logic [1:0] WrAddr2;
    logic [8:0] WrData2, Checksum2;
    logic [2:0] Count2;

    instr_stream_loader #(.IW(9), .AW(10)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .Operand(Operand), .Last(Last),
        .InValid(InValid), .InReady(InReady), .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
        .Busy(Busy), .Done(Done), .Error(Error), .Count(Count)
`ifdef LOADER_CHECKSUM_EN
        , .Checksum(Checksum)
`endif
    );

    instr_stream_loader #(.IW(9), .AW(2)) dut2 (
        .Clk(Clk), .Reset(Reset), .Start(Start2), .Op(Op), .Operand(Operand), .Last(Last),
        .InValid(InValid2), .InReady(InReady2), .WrEn(WrEn2), .WrAddr(WrAddr2), .WrData(WrData2),
        .Busy(Busy2), .Done(Done2), .Error(Error2), .Count(Count2)
`ifdef LOADER_CHECKSUM_EN
        , .Checksum(Checksum2)
`endif
    );

`ifndef LOADER_CHECKSUM_EN
    assign Checksum  = '0;
    assign Checksum2 = '0;
`endif

    int passed = 0, total = 0;
    logic [31:0] q1[$], q2[$];
    bit mLoad = 0, mDone = 0, mErr = 0;
    int mAddr = 0, mCount = 0;
    logic [8:0] mCk = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    logic [31:0] e1, e2;
    always @(negedge Clk) begin
        if (WrEn) begin
            if (q1.size() == 0) check("wr_unexpected", 32'(WrAddr), 32'hFFFF_FFFF);
            else begin
                e1 = q1.pop_front();
                check("wr_addr", 32'(WrAddr), e1 >> 9);
                check("wr_data", 32'(WrData), 32'(e1[8:0]));
            end
        end
    end

    always @(negedge Clk) begin
        if (WrEn2) begin
            if (q2.size() == 0) check("wr2_unexpected", 32'(WrAddr2), 32'hFFFF_FFFF);
            else begin
                e2 = q2.pop_front();
                check("wr2_addr", 32'(WrAddr2), e2 >> 9);
                check("wr2_data", 32'(WrData2), 32'(e2[8:0]));
            end
        end
    end

    task automatic startPulse(input bit withBeat);
        Start   = 1'b1;
        InValid = withBeat;
        Op      = kADDI;
        Operand = 5'h15;
        if (!mLoad) begin
            mLoad = 1; mDone = 0; mErr = 0; mAddr = 0; mCount = 0; mCk = '0;
        end
        tick();
        Start   = 1'b0;
        InValid = 1'b0;
    endtask

    task automatic beat(input logic [3:0] op, input logic [4:0] opnd, input bit last);
        Op = op; Operand = opnd; Last = last; InValid = 1'b1;
        if (mLoad) begin
            if (op == 4'b1111) begin
                mLoad = 0; mErr = 1;
            end else begin
                q1.push_back((32'(mAddr) << 9) | 32'({op, opnd}));
                mCk ^= {op, opnd};
                mCount++;
                mAddr++;
                if (last) begin mLoad = 0; mDone = 1; end
            end
        end
        tick();
        InValid = 1'b0;
        Last    = 1'b0;
    endtask

    task automatic status(input string tag);
        check({tag, "_done"}, 32'(Done), 32'(mDone));
        check({tag, "_error"}, 32'(Error), 32'(mErr));
        check({tag, "_busy"}, 32'(Busy), 32'(mLoad));
        check({tag, "_inready"}, 32'(InReady), 32'(mLoad));
        check({tag, "_count"}, 32'(Count), 32'(mCount));
        tick();
`ifdef LOADER_CHECKSUM_EN
        check({tag, "_checksum"}, 32'(Checksum), 32'(mCk));
`endif
    endtask

    task automatic checkReset(input string tag);
        check({tag, "_inready"}, 32'(InReady), 0);
        check({tag, "_wren"}, 32'(WrEn), 0);
        check({tag, "_wraddr"}, 32'(WrAddr), 0);
        check({tag, "_wrdata"}, 32'(WrData), 0);
        check({tag, "_busy"}, 32'(Busy), 0);
        check({tag, "_done"}, 32'(Done), 0);
        check({tag, "_error"}, 32'(Error), 0);
        check({tag, "_count"}, 32'(Count), 0);
        check({tag, "_checksum"}, 32'(Checksum), 0);
    endtask

    initial begin
        repeat (3) tick();
        checkReset("rst");
        Reset = 1'b0;
        tick();
        checkReset("idle");

        // back-to-back program of three words
        startPulse(0);
        beat(kADDI, 5'h03, 0);
        beat(kLDR, 5'h11, 0);
        beat(kBNZL, 5'h1F, 1);
        status("t1");
`ifdef LOADER_CHECKSUM_EN
        check("t1_checksum_lit", 32'(Checksum), 32'h0ED);
`endif

        // gaps between beats must not create address holes
        startPulse(0);
        check("t2_done_clr", 32'(Done), 0);
        for (int i = 0; i < 4; i++) begin
            beat(4'(i + 1), 5'(i * 3), i == 3);
            tick();
        end
        status("t2");

        // illegal opcode aborts, later beats are refused
        startPulse(0);
        beat(4'h1, 5'h02, 0);
        beat(kILLEGAL, 5'h07, 0);
        beat(4'h2, 5'h03, 1);
        status("t3");

        // overflow on the AW=2 instance
        Start2 = 1'b1;
        tick();
        Start2 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            Op = 4'(i + 1); Operand = 5'(i + 8); Last = 1'b0; InValid2 = 1'b1;
            if (i < 4) q2.push_back((32'(i) << 9) | 32'({Op, Operand}));
            tick();
            if (i == 3) begin
                check("t4_error_rise", 32'(Error2), 1);
                check("t4_count_rise", 32'(Count2), 4);
            end
        end
        InValid2 = 1'b0;
        tick();
        check("t4_error", 32'(Error2), 1);
        check("t4_inready", 32'(InReady2), 0);
        check("t4_count", 32'(Count2), 4);

        // reset mid-load, then a Start that arrives with a beat
        startPulse(0);
        beat(4'h3, 5'h01, 0);
        beat(4'h4, 5'h02, 0);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        mLoad = 0; mDone = 0; mErr = 0; mAddr = 0; mCount = 0; mCk = '0;
        checkReset("t5_rst");
        startPulse(1);
        beat(4'h6, 5'h0A, 1);
        status("t5");

        // Start ignored in LOAD, honoured in DONE
        startPulse(0);
        beat(4'h6, 5'h01, 0);
        startPulse(0);
        beat(4'h7, 5'h02, 1);
        status("t6a");
        startPulse(0);
        check("t6_done_clr", 32'(Done), 0);
        check("t6_busy", 32'(Busy), 1);
        beat(4'h8, 5'h03, 1);
        status("t6b");

        tick();
        tick();
        check("q1_drained", 32'(q1.size()), 0);
        check("q2_drained", 32'(q2.size()), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
